// File: rtl/fila_bytes_pkg.sv
// Shared types and defaults for the byte FIFO behind the deserializer.
package fila_pkg;

    // Enqueue handshake states: capture, acknowledge, wait for the held byte to drop.
    typedef enum logic [1:0] {
        F_IDLE      = 2'd0,
        F_ACK       = 2'd1,
        F_WAIT_DROP = 2'd2
    } fila_state_t;

    localparam int FILA_DEPTH_DEFAULT = 8;
    localparam int FILA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fila_bytes_mem.sv
// Byte storage for fila_bytes: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is, so data_out clears on reset.
module fila_mem
    import fila_pkg::*;
#(
    parameter int DEPTH = FILA_DEPTH_DEFAULT,
    parameter int WIDTH = FILA_WIDTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write the captured byte into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds the last popped byte until the next pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fila_bytes.sv
// Byte FIFO fed by the deserializer through a ready/ack handshake.
// Full FIFO withholds the ack, which stalls the deserializer upstream.
module fila_bytes
    import fila_pkg::*;
#(
    parameter int DEPTH = FILA_DEPTH_DEFAULT,
    parameter int WIDTH = FILA_WIDTH_DEFAULT
) (
    input  logic                     clk_100KHz,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_ready_in,
    output logic                     ack_out,
    input  logic                     dequeue_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   len_out,
    output logic                     full_out,
    output logic                     empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    fila_state_t   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic          enq_go;
    logic          deq_go;

    // Flags come from the registered occupancy so decisions use pre-edge state.
    assign full_out  = (len_q == LW'(DEPTH));
    assign empty_out = (len_q == '0);
    assign len_out   = len_q;

    // Handshake next-state and ack; a byte is captured only from F_IDLE when not full.
    always_comb begin
        state_d = state_q;
        enq_go  = 1'b0;
        ack_out = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (data_ready_in && !full_out) begin
                    enq_go  = 1'b1;
                    state_d = F_ACK;
                end
            end
            F_ACK: begin
                ack_out = 1'b1;
                state_d = F_WAIT_DROP;
            end
            F_WAIT_DROP: begin
                // Wait for the deserializer to release the byte so it is not taken twice.
                if (!data_ready_in) begin
                    state_d = F_IDLE;
                end
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    // Pointer and occupancy updates; pops on empty are ignored, no write-to-read bypass.
    always_comb begin
        deq_go   = dequeue_in && !empty_out;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        if (enq_go) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (deq_go) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({enq_go, deq_go})
            2'b10:   len_d = len_q + LW'(1);
            2'b01:   len_d = len_q - LW'(1);
            default: len_d = len_q;
        endcase
    end

    // State, pointers and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state_q  <= F_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
        end
    end

    fila_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_i   (clk_100KHz),
        .rst_i   (reset),
        .we_i    (enq_go),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (deq_go),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_fila_bytes.sv
// Scoreboard bench for fila_bytes: a queue-based reference model predicts each cycle,
// a separate monitor compares DUT outputs against the predictions.
module tb_fila_bytes;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk_100KHz = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             data_ready_in = 1'b0;
    logic             dequeue_in = 1'b0;
    logic             ack_out;
    logic [WIDTH-1:0] data_out;
    logic [3:0]       len_out;
    logic             full_out;
    logic             empty_out;

    fila_bytes #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_100KHz    (clk_100KHz),
        .reset         (reset),
        .data_in       (data_in),
        .data_ready_in (data_ready_in),
        .ack_out       (ack_out),
        .dequeue_in    (dequeue_in),
        .data_out      (data_out),
        .len_out       (len_out),
        .full_out      (full_out),
        .empty_out     (empty_out)
    );

    always #5 clk_100KHz = ~clk_100KHz;

    typedef struct packed {
        logic       ack;
        logic [3:0] len;
        logic [7:0] dout;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic       busy = 1'b0;
    logic       ack_prev = 1'b0;
    logic       last_acc = 1'b0;
    logic [7:0] dout_m = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the next prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100KHz);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ack_out",   ack_out,   e.ack);
                chk("len_out",   len_out,   e.len);
                chk("full_out",  full_out,  e.len == 4'(DEPTH));
                chk("empty_out", empty_out, e.len == 4'd0);
                chk("data_out",  data_out,  e.dout);
            end
        end
    end

    // One clock of stimulus; the reference model advances at the edge and posts its prediction.
    task automatic step(input logic dr, input logic [7:0] din, input logic dq);
        int  pre_size;
        logic acc, pop;
        exp_t e;
        data_ready_in = dr;
        data_in       = din;
        dequeue_in    = dq;
        @(posedge clk_100KHz);
        pre_size = mq.size();
        acc = dr && !busy && (pre_size != DEPTH);
        pop = dq && (pre_size != 0);
        if (pop) dout_m = mq.pop_front();
        if (acc) mq.push_back(din);
        if (acc) busy = 1'b1;
        else if (!ack_prev && !dr) busy = 1'b0;
        ack_prev = acc;
        last_acc = acc;
        e.ack  = acc;
        e.len  = 4'(mq.size());
        e.dout = dout_m;
        exp_q.push_back(e);
        @(negedge clk_100KHz);
    endtask

    // Behaves like the deserializer: hold the byte until captured, ride the ack, then drop.
    task automatic enq(input logic [7:0] b);
        int n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 50) begin
            step(1'b1, b, 1'b0);
            n++;
        end
        if (!last_acc) chk("enq_timeout", 32'd0, 32'd1);
        step(1'b1, b, 1'b0);
        step(1'b0, b, 1'b0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        data_ready_in = 1'b0;
        dequeue_in = 1'b0;
        mq.delete();
        exp_q.delete();
        busy = 1'b0;
        ack_prev = 1'b0;
        dout_m = 8'h00;
        #1;
        chk("rst_ack",   ack_out,   32'd0);
        chk("rst_len",   len_out,   32'd0);
        chk("rst_empty", empty_out, 32'd1);
        chk("rst_full",  full_out,  32'd0);
        chk("rst_dout",  data_out,  32'd0);
        @(negedge clk_100KHz);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk_100KHz);
        apply_reset();

        // Single byte round trip.
        enq(8'hA5);
        chk("t1_len", len_out, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_dout",  data_out,  32'hA5);
        chk("t1_empty", empty_out, 32'd1);

        // Fill, backpressure, pop while full, then drain.
        for (int i = 1; i <= 8; i++) enq(8'(i));
        chk("t2_full", full_out, 32'd1);
        chk("t2_len",  len_out,  32'd8);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h09, 1'b0);
        chk("t2_noack", ack_out, 32'd0);
        step(1'b1, 8'h09, 1'b1);
        chk("t2_pop1", data_out, 32'h01);
        enq(8'h09);
        chk("t2_refull", len_out, 32'd8);
        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t2_drain", data_out, 32'(i));
        end

        // A byte held for many cycles is captured once.
        for (int i = 0; i < 10; i++) step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t3_len", len_out, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("t3_dout", data_out, 32'h3C);

        // Pops on empty are ignored; no bypass on simultaneous enqueue and pop.
        apply_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_dout0", data_out, 32'h00);
        chk("t4_len0",  len_out,  32'd0);
        step(1'b1, 8'h77, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        chk("t4_len1",  len_out,  32'd1);
        chk("t4_dout1", data_out, 32'h00);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_pop", data_out, 32'h77);

        // Pointer wrap over many pairs, then simultaneous enqueue and pop at occupancy 4.
        for (int i = 0; i < 20; i++) begin
            enq(8'(i));
            step(1'b0, 8'h00, 1'b1);
            chk("t5_order", data_out, 32'(i));
        end
        for (int i = 0; i < 4; i++) enq(8'(8'h40 + i));
        step(1'b1, 8'h44, 1'b1);
        step(1'b1, 8'h44, 1'b0);
        chk("t5_len4", len_out, 32'd4);
        chk("t5_dout", data_out, 32'h40);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t5_drain", data_out, 32'(8'h40 + i));
        end

        // Reset in the ack cycle with three bytes held.
        enq(8'h11);
        enq(8'h22);
        step(1'b1, 8'h33, 1'b0);
        chk("t6_ack",  ack_out, 32'd1);
        chk("t6_len3", len_out, 32'd3);
        apply_reset();
        enq(8'h55);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_after", data_out, 32'h55);

        // Random traffic with an arbitrarily behaving upstream and consumer.
        begin
            logic       dr;
            logic [7:0] din;
            din = 8'($urandom);
            dr = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) dr = ~dr;
                if (!dr) din = 8'($urandom);
                step(dr, din, ($urandom_range(0, 2) == 0));
            end
        end

        @(negedge clk_100KHz);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
